// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Ports: clk, reset (async, active-high), start/cancel/op/A/B issue, busy stall, hi/lo state.
module mdu_iter #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int W2   = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [W2-1:0]    pend, pend_nx;
    logic             pend_wr, pend_wr_nx;
    logic [WIDTH-1:0] hi_nx, lo_nx;

    // Op class decode
    logic is_mthi, is_mtlo, is_mul, is_div, mul_signed;
    logic accept;

    assign is_mthi    = (op == OP_MTHI);
    assign is_mtlo    = (op == OP_MTLO);
    assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU) ||
                        (op == OP_MADD) || (op == OP_MADDU) ||
                        (op == OP_MSUB) || (op == OP_MSUBU);
    assign mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    assign accept     = start & ~cancel & ~busy &
                        (is_mthi | is_mtlo | is_mul | is_div);

    // Multiply / accumulate result
    logic [W2-1:0] prod, mac;

    always_comb begin
        if (mul_signed)
            prod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
        else
            prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        mac = prod;
        if ((op == OP_MADD) || (op == OP_MADDU))
            mac = {hi, lo} + prod;
        else if ((op == OP_MSUB) || (op == OP_MSUBU))
            mac = {hi, lo} - prod;
    end

    // Divide: signed form works on magnitudes, then restores signs.
    // Most-negative / -1 falls out as most-negative with remainder 0.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, b_s_safe, b_u_safe;
    logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [W2-1:0]    div_res;

    assign a_neg    = A[WIDTH-1];
    assign b_neg    = B[WIDTH-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;
    // Zero divisors are swapped for one; the result is discarded anyway.
    assign b_s_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
    assign b_u_safe = (B == '0) ? WIDTH'(1) : B;
    assign q_mag    = a_mag / b_s_safe;
    assign r_mag    = a_mag % b_s_safe;
    assign q_s      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s      = a_neg ? -r_mag : r_mag;
    assign q_u      = A / b_u_safe;
    assign r_u      = A % b_u_safe;
    assign div_res  = (op == OP_DIV) ? {r_s, q_s} : {r_u, q_u};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend    <= pend_nx;
            pend_wr <= pend_wr_nx;
            busy    <= (state_nx == RUN);
            hi      <= hi_nx;
            lo      <= lo_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_nx    = pend;
        pend_wr_nx = pend_wr;
        hi_nx      = hi;
        lo_nx      = lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_mthi: hi_nx = A;
                        is_mtlo: lo_nx = A;
                        is_mul: begin
                            pend_nx    = mac;
                            pend_wr_nx = 1'b1;
                            cnt_nx     = CW'(MULT_CYCLES);
                            state_nx   = RUN;
                        end
                        is_div: begin
                            pend_nx    = div_res;
                            pend_wr_nx = (B != '0);
                            cnt_nx     = CW'(DIV_CYCLES);
                            state_nx   = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx   = IDLE;
                    pend_wr_nx = 1'b0;
                    if (pend_wr)
                        {hi_nx, lo_nx} = pend;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
